// File: rtl/ddr_arb_pkg.sv
// Shared widths, the memory command record and helpers for the DDR port arbiter.
package ddr_arb_pkg;

  localparam int AddrW          = 32;
  localparam int DataW          = 64;
  localparam int BeW            = 8;
  localparam int WordOffsetBits = 3;

  // Requester id width; a single requester still needs one tag bit.
  function automatic int req_id_width(input int num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] data;
    logic [BeW-1:0]   byte_en;
    logic             write_en;
    logic             read_en;
  } mem_cmd_t;

endpackage

// File: rtl/ddr_arb_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each in-flight read.
module ddr_arb_tag_fifo #(
  parameter int Depth = 16,
  parameter int Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  // When full, a same-cycle pop frees the head slot that wr_ptr points at.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one DDR port among NumReq requesters; read beats
// are routed back to their originator through an in-order tag FIFO.
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NumReq         = 2,
  parameter int ReadLatency    = 16,
  parameter int MaxOutstanding = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  logic [NumReq-1:0]       req_write_i,
  input  logic [NumReq*AddrW-1:0] req_addr_i,
  input  logic [NumReq*DataW-1:0] req_data_i,
  input  logic [NumReq*BeW-1:0]   req_byte_en_i,
  output logic [NumReq-1:0]       rsp_valid_o,
  output logic [DataW-1:0]        rsp_data_o,
  output logic [AddrW-1:0]        mem_addr_o,
  output logic [DataW-1:0]        mem_data_o,
  output logic                    mem_write_en_o,
  output logic                    mem_read_en_o,
  output logic [BeW-1:0]          mem_byte_en_o,
  input  logic [DataW-1:0]        mem_data_i,
  input  logic                    mem_data_valid_i,
  output logic                    unaligned_o,
  output logic                    unexpected_rsp_o,
  output logic                    busy_o
);

  localparam int IdW = req_id_width(NumReq);
  localparam int DrW = $clog2(ReadLatency + 2);

  logic [NumReq-1:0][AddrW-1:0] addr_a;
  logic [NumReq-1:0][DataW-1:0] data_a;
  logic [NumReq-1:0][BeW-1:0]   be_a;

  logic [DrW-1:0]    drain_q;
  logic              draining;
  logic              rsp_beat, pop, push;
  logic              fifo_full, fifo_empty;
  logic [IdW-1:0]    fifo_head;
  logic [IdW-1:0]    rr_ptr_q;
  logic [NumReq-1:0] cand;
  logic              gnt_vld;
  logic [IdW-1:0]    gnt_id;
  mem_cmd_t          cmd_q, cmd_d;
  logic              unaligned_q, unexpected_q;

  assign addr_a = req_addr_i;
  assign data_a = req_data_i;
  assign be_a   = req_byte_en_i;

  // Drain outlasts any read still inside the memory pipeline across a reset.
  assign draining = (drain_q != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         drain_q <= DrW'(ReadLatency + 1);
    else if (draining) drain_q <= drain_q - 1'b1;
  end

  assign rsp_beat = mem_data_valid_i & ~draining;
  assign pop      = rsp_beat & ~fifo_empty;

  always_comb begin
    for (int k = 0; k < NumReq; k++)
      cand[k] = req_valid_i[k] & ~draining & (req_write_i[k] | ~fifo_full | pop);
  end

  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int i = 0; i < NumReq; i++) begin
      idx = (int'(rr_ptr_q) + i) % NumReq;
      if (!gnt_vld && cand[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = IdW'(idx);
      end
    end
  end

  assign req_ready_o = gnt_vld ? (NumReq'(1) << gnt_id) : '0;
  assign push        = gnt_vld & ~req_write_i[gnt_id];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        rr_ptr_q <= '0;
    else if (gnt_vld) rr_ptr_q <= (gnt_id == IdW'(NumReq - 1)) ? '0 : gnt_id + 1'b1;
  end

  // Address/data hold between commands; only the enables fall back to idle.
  always_comb begin
    cmd_d          = cmd_q;
    cmd_d.write_en = 1'b0;
    cmd_d.read_en  = 1'b0;
    if (gnt_vld) begin
      cmd_d.addr     = {addr_a[gnt_id][AddrW-1:WordOffsetBits], WordOffsetBits'(0)};
      cmd_d.write_en = req_write_i[gnt_id];
      cmd_d.read_en  = ~req_write_i[gnt_id];
      cmd_d.data     = req_write_i[gnt_id] ? data_a[gnt_id] : '0;
      cmd_d.byte_en  = req_write_i[gnt_id] ? be_a[gnt_id] : '1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cmd_q <= '0;
    else       cmd_q <= cmd_d;
  end

  assign mem_addr_o     = cmd_q.addr;
  assign mem_data_o     = cmd_q.data;
  assign mem_byte_en_o  = cmd_q.byte_en;
  assign mem_write_en_o = cmd_q.write_en;
  assign mem_read_en_o  = cmd_q.read_en;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      unaligned_q  <= 1'b0;
      unexpected_q <= 1'b0;
    end else begin
      if (gnt_vld && addr_a[gnt_id][WordOffsetBits-1:0] != '0) unaligned_q <= 1'b1;
      if (rsp_beat && fifo_empty)                              unexpected_q <= 1'b1;
    end
  end

  assign unaligned_o      = unaligned_q;
  assign unexpected_rsp_o = unexpected_q;

  ddr_arb_tag_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdW)
  ) u_tag_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (gnt_id),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  assign rsp_valid_o = pop ? (NumReq'(1) << fifo_head) : '0;
  assign rsp_data_o  = pop ? mem_data_i : '0;
  assign busy_o      = ~fifo_empty | draining;

endmodule
